// File: rtl/dmi_arb_pkg.sv
// DMI arbiter shared types.
// FSM states, sticky status codes and requester ids.
package dmi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK     = 2'b00,
    STAT_FAILED = 2'b10,
    STAT_BUSY   = 2'b11
  } stat_e;

  typedef enum logic {
    ID_JTAG = 1'b0,
    ID_SYS  = 1'b1
  } req_id_e;

  // busy outranks failed; failed never hides busy
  function automatic stat_e stat_merge(
    input stat_e cur,
    input stat_e nu
  );
    return (cur == STAT_BUSY) ? STAT_BUSY : nu;
  endfunction

endpackage

// File: rtl/dmi_arbiter_if.sv
// Shared DMI bus between the arbiter (master)
// and the debug module (slave).
interface dmi_arbiter_if #(
  parameter int AWIDTH = 7
);

  logic              dmi_req;
  logic              dmi_we;
  logic [AWIDTH-1:0] dmi_addr;
  logic [31:0]       dmi_wdata;
  logic              dmi_ack;
  logic [31:0]       dmi_rdata;

  modport master (
    output dmi_req,
    output dmi_we,
    output dmi_addr,
    output dmi_wdata,
    input  dmi_ack,
    input  dmi_rdata
  );

  modport slave (
    input  dmi_req,
    input  dmi_we,
    input  dmi_addr,
    input  dmi_wdata,
    output dmi_ack,
    output dmi_rdata
  );

endinterface

// File: rtl/dmi_rr_arb2.sv
// Two-way round-robin grant; the pointer holds the
// last granted id and starts at SYS so JTAG wins first.
module dmi_rr_arb2
  import dmi_arb_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    req_j_i,
  input  logic    req_s_i,
  input  logic    upd_i,
  output logic    gnt_o,
  output req_id_e gnt_id_o
);

  req_id_e last_q, last_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_q <= ID_SYS;
    else         last_q <= last_d;
  end

  always_comb begin
    gnt_o    = req_j_i | req_s_i;
    gnt_id_o = ID_JTAG;
    unique case (1'b1)
      req_j_i && req_s_i:
        gnt_id_o = (last_q == ID_JTAG) ? ID_SYS : ID_JTAG;
      !req_j_i && req_s_i:
        gnt_id_o = ID_SYS;
      default:
        gnt_id_o = ID_JTAG;
    endcase
    last_d = (upd_i && gnt_o) ? gnt_id_o : last_q;
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Arbitrates JTAG DTM and system requests onto one DMI
// bus with timeout and sticky JTAG status.
module dmi_arbiter
  import dmi_arb_pkg::*;
#(
  parameter int         AWIDTH    = 7,
  parameter int         TIMEOUT   = 255,
  parameter logic [2:0] IDLE_HINT = 3'd1
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              j_wr_en,
  input  logic              j_rd_en,
  input  logic [AWIDTH-1:0] j_addr,
  input  logic [31:0]       j_wdata,
  input  logic              j_dmi_reset,
  input  logic              j_dmi_hard_reset,
  output logic [31:0]       j_rd_data,
  output logic [1:0]        j_rd_status,
  output logic [1:0]        dmi_stat,
  output logic [2:0]        idle,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic [31:0]       s_wdata,
  output logic              s_done,
  output logic [31:0]       s_rdata,
  output logic              s_err,
  dmi_arbiter_if.master     dmi
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  req_id_e           gnt_q, gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              jp_q, jp_d;
  logic              jwe_q, jwe_d;
  logic [AWIDTH-1:0] jaddr_q, jaddr_d;
  logic [31:0]       jwdata_q, jwdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       jrd_q, jrd_d;
  stat_e             stat_q, stat_d;
  logic [31:0]       srd_q, srd_d;
  logic              serr_q, serr_d;

  logic    j_pulse, j_busy, j_take, arb_gnt;
  req_id_e arb_id;

  assign j_pulse = j_wr_en | j_rd_en;
  assign j_busy  = jp_q |
                   (state_q != ST_IDLE && gnt_q == ID_JTAG);
  assign j_take  = j_pulse & ~j_busy & ~j_dmi_hard_reset;

  dmi_rr_arb2 u_rr (
    .clk_i    (tck),
    .rst_ni   (trst),
    .req_j_i  (jp_q | j_take),
    .req_s_i  (s_req),
    .upd_i    (state_q == ST_IDLE && !j_dmi_hard_reset),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id)
  );

  always_ff @(posedge tck) begin
    if (!trst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= ID_JTAG;
      cnt_q    <= '0;
      jp_q     <= 1'b0;
      jwe_q    <= 1'b0;
      jaddr_q  <= '0;
      jwdata_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      jrd_q    <= '0;
      stat_q   <= STAT_OK;
      srd_q    <= '0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      jp_q     <= jp_d;
      jwe_q    <= jwe_d;
      jaddr_q  <= jaddr_d;
      jwdata_q <= jwdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      jrd_q    <= jrd_d;
      stat_q   <= stat_d;
      srd_q    <= srd_d;
      serr_q   <= serr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    jp_d     = jp_q;
    jwe_d    = jwe_q;
    jaddr_d  = jaddr_q;
    jwdata_d = jwdata_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    jrd_d    = jrd_q;
    stat_d   = stat_q;
    srd_d    = srd_q;
    serr_d   = serr_q;

    if (j_take) begin
      jp_d     = 1'b1;
      jwe_d    = j_wr_en;
      jaddr_d  = j_addr;
      jwdata_d = j_wdata;
    end
    if (j_pulse && j_busy) stat_d = STAT_BUSY;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt) begin
          state_d = ST_REQ;
          gnt_d   = arb_id;
          cnt_d   = '0;
          req_d   = 1'b1;
          if (arb_id == ID_JTAG) begin
            // a fresh pulse bypasses the slot
            jp_d    = 1'b0;
            we_d    = jp_q ? jwe_q    : j_wr_en;
            addr_d  = jp_q ? jaddr_q  : j_addr;
            wdata_d = jp_q ? jwdata_q : j_wdata;
          end else begin
            we_d    = s_we;
            addr_d  = s_addr;
            wdata_d = s_wdata;
          end
        end
      end
      ST_REQ: begin
        if (dmi.dmi_ack) begin
          req_d   = 1'b0;
          state_d = ST_RESP;
          if (gnt_q == ID_JTAG) begin
            if (!we_q) jrd_d = dmi.dmi_rdata;
          end else begin
            srd_d  = dmi.dmi_rdata;
            serr_d = 1'b0;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          state_d = ST_RESP;
          if (gnt_q == ID_JTAG) begin
            stat_d = stat_merge(stat_d, STAT_FAILED);
          end else begin
            srd_d  = '0;
            serr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (j_dmi_reset) stat_d = STAT_OK;
    if (j_dmi_hard_reset) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      jp_d    = 1'b0;
      stat_d  = STAT_OK;
    end
  end

  assign dmi.dmi_req   = req_q;
  assign dmi.dmi_we    = we_q;
  assign dmi.dmi_addr  = addr_q;
  assign dmi.dmi_wdata = wdata_q;

  assign j_rd_data   = jrd_q;
  assign j_rd_status = stat_q;
  assign dmi_stat    = stat_q;
  assign idle        = IDLE_HINT;
  assign s_done      = (state_q == ST_RESP) && (gnt_q == ID_SYS);
  assign s_rdata     = srd_q;
  assign s_err       = serr_q;

endmodule
